// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and select constants for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_F = 2'b01,
    BUSY_D = 2'b10
  } arb_state_t;

  localparam logic SEL_F = 1'b0;
  localparam logic SEL_D = 1'b1;

  // Width of a counter that must hold 0..max_starve (at least one bit).
  function automatic int cnt_width(input int max_starve);
    return (max_starve < 1) ? 1 : $clog2(max_starve + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the single-ported unified memory
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_f,
  input  logic [ADDR_W-1:0] addr_f,
  output logic              done_f,
  output logic [DATA_W-1:0] rdata_f,
  input  logic              req_d,
  input  logic              we_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] wdata_d,
  output logic              done_d,
  output logic [DATA_W-1:0] rdata_d,
  output logic              mem_req,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int CNT_W = cnt_width(MAX_STARVE);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

  arb_state_t       state, state_nx;
  logic [CNT_W-1:0] starve_cnt;
  logic             eff_f, eff_d;
  logic             grant_f, grant_d;
  logic             finish;

  // A requester is not eligible in its own done cycle, so a dropping request is never re-granted.
  assign eff_f = req_f & ~done_f;
  assign eff_d = req_d & ~done_d;

  // Data wins a tie until fetch has been passed over MAX_STARVE times in a row.
  assign grant_d = (state == IDLE) & eff_d & (~eff_f | (starve_cnt < STARVE_MAX));
  assign grant_f = (state == IDLE) & eff_f & ~grant_d;
  assign finish  = (state != IDLE) & mem_ready;
  assign busy    = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state: grant from IDLE, return to IDLE when the memory completes.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nx = BUSY_D;
        else if (grant_f) state_nx = BUSY_F;
      end
      BUSY_F, BUSY_D: begin
        if (mem_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Latch the winner's request fields, drive the memory strobe and return data with a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req    <= 1'b0;
      mem_sel    <= SEL_F;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata_f    <= '0;
      rdata_d    <= '0;
      done_f     <= 1'b0;
      done_d     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      done_f <= 1'b0;
      done_d <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_sel   <= SEL_D;
        mem_we    <= we_d;
        mem_addr  <= addr_d;
        mem_wdata <= wdata_d;
        if (!eff_f)                       starve_cnt <= '0;
        else if (starve_cnt < STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
      end else if (grant_f) begin
        mem_req    <= 1'b1;
        mem_sel    <= SEL_F;
        mem_we     <= 1'b0;
        mem_addr   <= addr_f;
        starve_cnt <= '0;
      end else if (finish) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (state == BUSY_D) begin
          rdata_d <= mem_rdata;
          done_d  <= 1'b1;
        end else begin
          rdata_f <= mem_rdata;
          done_f  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAX_STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_f, req_d, we_d, mem_ready;
  logic [31:0] addr_f, addr_d, wdata_d, mem_rdata;
  logic        done_f, done_d, mem_req, mem_sel, mem_we, busy;
  logic [31:0] rdata_f, rdata_d, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one outstanding access record plus the skipped-fetch tally.
  bit        m_busy, m_who, m_we, m_done_f, m_done_d;
  bit [31:0] m_addr, m_wdata, m_rdata_f, m_rdata_d;
  int        m_cnt;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .rst(rst),
    .req_f(req_f), .addr_f(addr_f), .done_f(done_f), .rdata_f(rdata_f),
    .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d),
    .done_d(done_d), .rdata_d(rdata_d),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_who = 0; m_we = 0; m_done_f = 0; m_done_d = 0;
    m_addr = 0; m_wdata = 0; m_rdata_f = 0; m_rdata_d = 0; m_cnt = 0;
  endtask

  task automatic idle_inputs();
    req_f = 0; req_d = 0; we_d = 0; mem_ready = 0;
    addr_f = 0; addr_d = 0; wdata_d = 0; mem_rdata = 0;
  endtask

  // Advance one clock and move the model by the same edge; returns 1 ns after the edge.
  task automatic cycle();
    bit ef, ed, gd, gf, fin;
    bit [31:0] a_f, a_d, w_d, rd;
    bit wd;
    ef = req_f && !m_done_f;
    ed = req_d && !m_done_d;
    gd = !m_busy && ed && (!ef || m_cnt < MAX_STARVE);
    gf = !m_busy && ef && !gd;
    fin = m_busy && mem_ready;
    a_f = addr_f; a_d = addr_d; w_d = wdata_d; wd = we_d; rd = mem_rdata;
    @(posedge clk);
    #1;
    m_done_f = 0;
    m_done_d = 0;
    if (gd) begin
      m_busy = 1; m_who = 1; m_addr = a_d; m_wdata = w_d; m_we = wd;
      m_cnt = ef ? ((m_cnt + 1 > MAX_STARVE) ? MAX_STARVE : m_cnt + 1) : 0;
    end else if (gf) begin
      m_busy = 1; m_who = 0; m_addr = a_f; m_we = 0; m_cnt = 0;
    end else if (fin) begin
      m_busy = 0;
      if (m_who) begin m_done_d = 1; m_rdata_d = rd; end
      else       begin m_done_f = 1; m_rdata_f = rd; end
    end
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({mem_req, mem_sel, mem_we, done_f, done_d, busy} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_sel, mem_we, done_f, done_d, busy});
    end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if ({rdata_f, rdata_d} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", {rdata_f, rdata_d}); end
    rst = 1;
    cycle();
  endtask

  task automatic test_f_read();
    req_f = 1; addr_f = 32'h100;
    cycle();
    n_cmp++; if ({mem_req, mem_sel, busy} !== 3'b101) begin
      n_bad++; $display("FAIL f_grant: got req/sel/busy %b want 101", {mem_req, mem_sel, busy});
    end
    n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL f_addr: got %h want 100", mem_addr); end
    addr_f = 32'h3f0;
    cycle();
    cycle();
    mem_ready = 1; mem_rdata = 32'h00500093;
    cycle();
    mem_ready = 0; mem_rdata = 32'h0;
    n_cmp++; if ({done_f, done_d, mem_req} !== 3'b100) begin
      n_bad++; $display("FAIL f_done: got done_f/done_d/req %b want 100", {done_f, done_d, mem_req});
    end
    n_cmp++; if (rdata_f !== 32'h00500093) begin n_bad++; $display("FAIL f_rdata: got %h want 00500093", rdata_f); end
    cycle();
    n_cmp++; if ({done_f, mem_req, busy} !== 3'b000) begin
      n_bad++; $display("FAIL f_no_regrant: got done/req/busy %b want 000", {done_f, mem_req, busy});
    end
    req_f = 0;
    cycle();
  endtask

  task automatic test_d_write();
    req_d = 1; we_d = 1; addr_d = 32'h2000; wdata_d = 32'hDEADBEEF;
    cycle();
    n_cmp++; if ({mem_req, mem_sel, mem_we} !== 3'b111) begin
      n_bad++; $display("FAIL d_grant: got req/sel/we %b want 111", {mem_req, mem_sel, mem_we});
    end
    n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL d_wdata: got %h want deadbeef", mem_wdata); end
    n_cmp++; if (mem_addr !== 32'h2000) begin n_bad++; $display("FAIL d_addr: got %h want 2000", mem_addr); end
    mem_ready = 1;
    cycle();
    mem_ready = 0;
    n_cmp++; if ({done_d, done_f, mem_req, mem_we} !== 4'b1000) begin
      n_bad++; $display("FAIL d_done: got done_d/done_f/req/we %b want 1000", {done_d, done_f, mem_req, mem_we});
    end
    cycle();
    n_cmp++; if ({done_d, mem_req} !== 2'b00) begin
      n_bad++; $display("FAIL d_no_regrant: got done/req %b want 00", {done_d, mem_req});
    end
    req_d = 0; we_d = 0;
    cycle();
  endtask

  task automatic test_simultaneous();
    req_f = 1; addr_f = 32'h400; req_d = 1; we_d = 0; addr_d = 32'h800;
    cycle();
    n_cmp++; if ({mem_req, mem_sel} !== 2'b11) begin
      n_bad++; $display("FAIL tie_d_first: got req/sel %b want 11", {mem_req, mem_sel});
    end
    mem_ready = 1; mem_rdata = 32'h12345678;
    cycle();
    n_cmp++; if ({done_d, rdata_d} !== {1'b1, 32'h12345678}) begin
      n_bad++; $display("FAIL tie_d_done: got %b/%h want 1/12345678", done_d, rdata_d);
    end
    req_d = 0; mem_ready = 0;
    cycle();
    n_cmp++; if ({mem_req, mem_sel, mem_addr} !== {2'b10, 32'h400}) begin
      n_bad++; $display("FAIL tie_f_next: got req/sel %b addr %h want 10 addr 400", {mem_req, mem_sel}, mem_addr);
    end
    n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_bad++; $display("FAIL tie_cnt: got %0d want 0", dut.starve_cnt); end
    mem_ready = 1;
    cycle();
    req_f = 0; mem_ready = 0;
    cycle();
  endtask

  task automatic test_starvation();
    for (int i = 0; i <= MAX_STARVE; i++) begin
      req_f = 1; req_d = 1; we_d = 0; addr_f = 32'h10 + i; addr_d = 32'h20 + i;
      cycle();
      n_cmp++; if (mem_sel !== (i < MAX_STARVE)) begin
        n_bad++; $display("FAIL starve_grant%0d: got sel %b want %b", i, mem_sel, i < MAX_STARVE);
      end
      n_cmp++; if (dut.starve_cnt !== 3'((i < MAX_STARVE) ? i + 1 : 0)) begin
        n_bad++; $display("FAIL starve_cnt%0d: got %0d want %0d", i, dut.starve_cnt, (i < MAX_STARVE) ? i + 1 : 0);
      end
      mem_ready = 1;
      cycle();
      req_f = 0; req_d = 0; mem_ready = 0;
      cycle();
    end
  endtask

  task automatic test_spurious_and_hold();
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++; if ({done_f, done_d, mem_req, busy} !== 4'b0) begin
        n_bad++; $display("FAIL spurious%0d: got done_f/done_d/req/busy %b want 0000", i, {done_f, done_d, mem_req, busy});
      end
    end
    mem_ready = 0;
    req_d = 1; we_d = 0; addr_d = 32'h40;
    cycle();
    addr_d = 32'h80; we_d = 1; wdata_d = 32'h55;
    cycle();
    n_cmp++; if ({mem_addr, mem_we} !== {32'h40, 1'b0}) begin
      n_bad++; $display("FAIL hold_fields: got addr %h we %b want addr 40 we 0", mem_addr, mem_we);
    end
    mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    cycle();
    n_cmp++; if ({done_d, rdata_d} !== {1'b1, 32'hCAFEF00D}) begin
      n_bad++; $display("FAIL hold_done: got %b/%h want 1/cafef00d", done_d, rdata_d);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_reset_mid_access();
    req_f = 1; req_d = 1; we_d = 1; addr_d = 32'h77;
    cycle();
    #2;
    rst = 0;
    #1;
    model_reset();
    n_cmp++; if ({mem_req, busy, done_f, done_d} !== 4'b0) begin
      n_bad++; $display("FAIL rst_mid: got req/busy/done_f/done_d %b want 0000", {mem_req, busy, done_f, done_d});
    end
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1;
    cycle();
    n_cmp++; if ({busy, mem_req, dut.starve_cnt} !== 5'b0) begin
      n_bad++; $display("FAIL rst_after: got busy/req/cnt %b want 00000", {busy, mem_req, dut.starve_cnt});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (done_f) req_f = ($urandom_range(0, 3) == 0);
      else if (!req_f) req_f = ($urandom_range(0, 1) == 0);
      if (done_d) req_d = ($urandom_range(0, 3) == 0);
      else if (!req_d) req_d = ($urandom_range(0, 1) == 0);
      addr_f = $urandom; addr_d = $urandom; wdata_d = $urandom; we_d = $urandom_range(0, 1);
      mem_ready = ($urandom_range(0, 2) == 0); mem_rdata = $urandom;
      cycle();
      n_cmp++; if ({done_f, done_d} !== {m_done_f, m_done_d}) begin
        n_bad++; $display("FAIL rnd_done@%0d: got %b want %b", i, {done_f, done_d}, {m_done_f, m_done_d});
      end
      n_cmp++; if ({mem_req, busy, mem_we} !== {m_busy, m_busy, m_busy & m_we}) begin
        n_bad++; $display("FAIL rnd_ctrl@%0d: got req/busy/we %b want %b", i, {mem_req, busy, mem_we}, {m_busy, m_busy, m_busy & m_we});
      end
      if (m_busy) begin
        n_cmp++; if ({mem_sel, mem_addr} !== {m_who, m_addr}) begin
          n_bad++; $display("FAIL rnd_sel_addr@%0d: got %b/%h want %b/%h", i, mem_sel, mem_addr, m_who, m_addr);
        end
        if (m_who && m_we) begin
          n_cmp++; if (mem_wdata !== m_wdata) begin
            n_bad++; $display("FAIL rnd_wdata@%0d: got %h want %h", i, mem_wdata, m_wdata);
          end
        end
      end
      if (m_done_f) begin
        n_cmp++; if (rdata_f !== m_rdata_f) begin n_bad++; $display("FAIL rnd_rdata_f@%0d: got %h want %h", i, rdata_f, m_rdata_f); end
      end
      if (m_done_d && !m_we) begin
        n_cmp++; if (rdata_d !== m_rdata_d) begin n_bad++; $display("FAIL rnd_rdata_d@%0d: got %h want %h", i, rdata_d, m_rdata_d); end
      end
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    test_reset();
    test_f_read();
    test_d_write();
    test_simultaneous();
    test_starvation();
    test_spurious_and_hold();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
